// File: rtl/sext_arbiter.sv
// Two-requester arbiter in front of a shared sign-extender: grants one operation
// at a time, waits EXT_WAIT settle cycles, then holds the captured result until accepted.
module sext_arbiter #(
  parameter int FAIR     = 1,
  parameter int EXT_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [3:0]  msb0,
  input  logic [3:0]  msb1,
  input  logic        shf0,
  input  logic        shf1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] ext_in,
  output logic [3:0]  ext_msb,
  output logic        ext_shift,
  input  logic [15:0] ext_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(EXT_WAIT);

  state_t      state_q, state_d;
  logic        grant;
  logic        winner;
  logic        last_gnt_q;
  logic [3:0]  wait_cnt_q;
  logic [15:0] op_in_q;
  logic [3:0]  op_msb_q;
  logic        op_shf_q;
  logic        ack0_q, ack1_q;
  logic [15:0] rsp_data_q;
  logic        rsp_id_q;

  // Requests are only looked at in IDLE; a contested round-robin grant goes
  // to whoever did not win last time.
  assign grant  = (state_q == IDLE) && (req0 || req1);
  assign winner = (req0 && req1) ? ((FAIR != 0) ? ~last_gnt_q : 1'b0) : req1;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = WAIT;
      WAIT:    if (wait_cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      op_in_q    <= 16'h0000;
      op_msb_q   <= 4'd0;
      op_shf_q   <= 1'b0;
      last_gnt_q <= 1'b1;
      wait_cnt_q <= 4'd0;
      rsp_data_q <= 16'h0000;
      rsp_id_q   <= 1'b0;
    end else begin
      ack0_q <= grant && !winner;
      ack1_q <= grant && winner;
      if (grant) begin
        op_in_q    <= winner ? in1  : in0;
        op_msb_q   <= winner ? msb1 : msb0;
        op_shf_q   <= winner ? shf1 : shf0;
        last_gnt_q <= winner;
        wait_cnt_q <= WAIT_INIT;
      end
      if (state_q == WAIT) begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
        end else begin
          rsp_data_q <= ext_out;
          rsp_id_q   <= last_gnt_q;
        end
      end
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign ext_in    = op_in_q;
  assign ext_msb   = op_msb_q;
  assign ext_shift = op_shf_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sext_arbiter.sv
// Bench for sext_arbiter: a round-robin/no-wait instance and a fixed-priority/3-wait
// instance share stimulus; a transaction-level model checks both every cycle.
module tb_sext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, shf0, shf1, rsp_ready;
  logic [15:0] in0, in1;
  logic [3:0]  msb0, msb1;

  logic        a_ack0, a_ack1, a_ext_shift, a_rsp_valid, a_rsp_id;
  logic [15:0] a_ext_in, a_ext_out, a_rsp_data;
  logic [3:0]  a_ext_msb;
  logic        b_ack0, b_ack1, b_ext_shift, b_rsp_valid, b_rsp_id;
  logic [15:0] b_ext_in, b_ext_out, b_rsp_data;
  logic [3:0]  b_ext_msb;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Reference sign extender: optional shift-left-by-one, then replicate bit msb upward.
  function automatic logic [15:0] sext(input logic [15:0] v, input logic [3:0] m, input logic s);
    logic [15:0] x;
    logic [15:0] r;
    x = s ? (v << 1) : v;
    for (int b = 0; b < 16; b++) r[b] = (b > int'(m)) ? x[m] : x[b];
    return r;
  endfunction

  assign a_ext_out = sext(a_ext_in, a_ext_msb, a_ext_shift);
  assign b_ext_out = sext(b_ext_in, b_ext_msb, b_ext_shift);

  sext_arbiter #(.FAIR(1), .EXT_WAIT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .in0(in0), .in1(in1), .msb0(msb0), .msb1(msb1), .shf0(shf0), .shf1(shf1),
    .ack0(a_ack0), .ack1(a_ack1), .ext_in(a_ext_in), .ext_msb(a_ext_msb),
    .ext_shift(a_ext_shift), .ext_out(a_ext_out), .rsp_valid(a_rsp_valid),
    .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .rsp_ready(rsp_ready)
  );

  sext_arbiter #(.FAIR(0), .EXT_WAIT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .in0(in0), .in1(in1), .msb0(msb0), .msb1(msb1), .shf0(shf0), .shf1(shf1),
    .ack0(b_ack0), .ack1(b_ack1), .ext_in(b_ext_in), .ext_msb(b_ext_msb),
    .ext_shift(b_ext_shift), .ext_out(b_ext_out), .rsp_valid(b_rsp_valid),
    .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_ready(rsp_ready)
  );

  // Transaction model: an operation is "in flight" from its grant until the
  // consumer takes it; ack and response times are absolute cycle numbers.
  bit          m_busy[2];
  logic        m_last[2];
  logic        m_id[2];
  int          m_ack_cyc[2];
  int          m_rsp_at[2];
  logic [15:0] m_op_in[2];
  logic [3:0]  m_op_msb[2];
  logic        m_op_shf[2];
  logic [15:0] m_data[2];

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit fair_of(input int i);
    return (i == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i]    = 1'b0;
      m_last[i]    = 1'b1;
      m_id[i]      = 1'b0;
      m_ack_cyc[i] = -10;
      m_rsp_at[i]  = 0;
      m_op_in[i]   = 16'h0000;
      m_op_msb[i]  = 4'd0;
      m_op_shf[i]  = 1'b0;
      m_data[i]    = 16'h0000;
    end
  endtask

  task automatic model_step();
    logic w;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (req0 || req1) begin
            if (req0 && req1) w = fair_of(i) ? !m_last[i] : 1'b0;
            else              w = req1;
            m_last[i]    = w;
            m_id[i]      = w;
            m_busy[i]    = 1'b1;
            m_ack_cyc[i] = cyc + 1;
            m_rsp_at[i]  = cyc + 2 + wait_of(i);
            m_op_in[i]   = w ? in1 : in0;
            m_op_msb[i]  = w ? msb1 : msb0;
            m_op_shf[i]  = w ? shf1 : shf0;
            m_data[i]    = sext(m_op_in[i], m_op_msb[i], m_op_shf[i]);
          end
        end else if (cyc >= m_rsp_at[i] && rsp_ready) begin
          m_busy[i] = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic ack0, input logic ack1,
                          input logic [15:0] ein, input logic [3:0] emsb, input logic esh,
                          input logic rv, input logic rid, input logic [15:0] rdata);
    bit exp_valid;
    exp_valid = m_busy[i] && (cyc >= m_rsp_at[i]);
    check($sformatf("u%0d ack0", i), 32'(ack0), 32'((cyc == m_ack_cyc[i]) && (m_id[i] == 1'b0)));
    check($sformatf("u%0d ack1", i), 32'(ack1), 32'((cyc == m_ack_cyc[i]) && (m_id[i] == 1'b1)));
    check($sformatf("u%0d ext_in", i), 32'(ein), 32'(m_op_in[i]));
    check($sformatf("u%0d ext_msb", i), 32'(emsb), 32'(m_op_msb[i]));
    check($sformatf("u%0d ext_shift", i), 32'(esh), 32'(m_op_shf[i]));
    check($sformatf("u%0d rsp_valid", i), 32'(rv), 32'(exp_valid));
    if (exp_valid) begin
      check($sformatf("u%0d rsp_id", i), 32'(rid), 32'(m_id[i]));
      check($sformatf("u%0d rsp_data", i), 32'(rdata), 32'(m_data[i]));
    end
  endtask

  // One clock: the model advances on the edge, outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_inst(0, a_ack0, a_ack1, a_ext_in, a_ext_msb, a_ext_shift, a_rsp_valid, a_rsp_id, a_rsp_data);
    cmp_inst(1, b_ack0, b_ack1, b_ext_in, b_ext_msb, b_ext_shift, b_rsp_valid, b_rsp_id, b_rsp_data);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " a outputs"}, {a_ack0, a_ack1, a_rsp_valid, a_rsp_id, a_ext_shift, 27'd0}, 32'd0);
    check({tag, " a rsp_data"}, 32'(a_rsp_data), 32'd0);
    check({tag, " a ext_in"}, {12'd0, a_ext_msb, a_ext_in}, 32'd0);
    check({tag, " b outputs"}, {b_ack0, b_ack1, b_rsp_valid, b_rsp_id, b_ext_shift, 27'd0}, 32'd0);
    check({tag, " b rsp_data"}, 32'(b_rsp_data), 32'd0);
    check({tag, " b ext_in"}, {12'd0, b_ext_msb, b_ext_in}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        r0, r1;
    logic [15:0] i0, i1;
    logic [3:0]  m0, m1;
    logic        s0, s1;
    logic        eid;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs[8];
  logic ga[$];
  logic gb[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Expected results for the round-robin instance, starting from reset (last_gnt=1).
    vecs[0] = '{1'b1, 1'b0, 16'h0080, 16'h0000, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0, 16'hFF80};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0040, 4'd0,  4'd7, 1'b0, 1'b1, 1'b1, 16'hFF80};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h0020, 4'd0,  4'd7, 1'b0, 1'b1, 1'b1, 16'h0040};
    vecs[3] = '{1'b1, 1'b1, 16'h7FFF, 16'h8000, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 16'h7FFF};
    vecs[4] = '{1'b1, 1'b1, 16'h1111, 16'h0008, 4'd0,  4'd3, 1'b0, 1'b0, 1'b1, 16'hFFF8};
    vecs[5] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    vecs[6] = '{1'b1, 1'b0, 16'hABCD, 16'h0000, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0, 16'h579A};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h1234, 4'd0,  4'd4, 1'b0, 1'b0, 1'b1, 16'hFFF4};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; shf0 = 1'b0; shf1 = 1'b0;
    in0 = 16'h0; in1 = 16'h0; msb0 = 4'd0; msb1 = 4'd0; rsp_ready = 1'b1;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single operations: ack one cycle after sampling, result one cycle later.
    foreach (vecs[k]) begin
      req0 = vecs[k].r0; req1 = vecs[k].r1;
      in0 = vecs[k].i0; in1 = vecs[k].i1;
      msb0 = vecs[k].m0; msb1 = vecs[k].m1;
      shf0 = vecs[k].s0; shf1 = vecs[k].s1;
      rsp_ready = 1'b1;
      tick();
      req0 = 1'b0; req1 = 1'b0;
      check($sformatf("vec%0d ack", k), 32'(vecs[k].eid ? a_ack1 : a_ack0), 32'd1);
      check($sformatf("vec%0d other ack", k), 32'(vecs[k].eid ? a_ack0 : a_ack1), 32'd0);
      check($sformatf("vec%0d early valid", k), 32'(a_rsp_valid), 32'd0);
      tick();
      check($sformatf("vec%0d valid", k), 32'(a_rsp_valid), 32'd1);
      check($sformatf("vec%0d rsp_id", k), 32'(a_rsp_id), 32'(vecs[k].eid));
      check($sformatf("vec%0d rsp_data", k), 32'(a_rsp_data), 32'(vecs[k].edata));
      repeat (6) tick();
    end

    // Contention: both requests held, consumer always ready.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
    repeat (20) begin
      tick();
      if (a_ack0) ga.push_back(1'b0);
      if (a_ack1) ga.push_back(1'b1);
      if (b_ack0) gb.push_back(1'b0);
      if (b_ack1) gb.push_back(1'b1);
    end
    check("rr grant count", 32'(ga.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < ga.size(); k++)
      check($sformatf("rr grant %0d", k), 32'(ga[k]), 32'(k % 2));
    check("fixed grant count", 32'(gb.size() >= 3), 32'd1);
    for (int k = 0; k < 3 && k < gb.size(); k++)
      check($sformatf("fixed grant %0d", k), 32'(gb[k]), 32'd0);

    // Backpressure: result held five cycles while req1 waits.
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) tick();
    in0 = 16'h00F0; msb0 = 4'd7; shf0 = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0; req1 = 1'b1; in1 = 16'h0005; msb1 = 4'd2; shf1 = 1'b0; rsp_ready = 1'b0;
    for (int t = 0; t < 10 && !a_rsp_valid; t++) tick();
    check("bp valid reached", 32'(a_rsp_valid), 32'd1);
    for (int t = 0; t < 5; t++) begin
      check($sformatf("bp hold valid %0d", t), 32'(a_rsp_valid), 32'd1);
      check($sformatf("bp hold data %0d", t), 32'(a_rsp_data), 32'h0000FFF0);
      check($sformatf("bp hold id %0d", t), 32'(a_rsp_id), 32'd0);
      check($sformatf("bp no ack %0d", t), 32'(a_ack1), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp idle after release", 32'(a_rsp_valid), 32'd0);
    tick();
    check("bp ack1 after release", 32'(a_ack1), 32'd1);
    req1 = 1'b0;
    repeat (10) tick();

    // Fixed latency: cycles from the sampling edge to first rsp_valid.
    begin
      int fa, fb;
      fa = -1; fb = -1;
      in0 = 16'h0080; msb0 = 4'd7; shf0 = 1'b0; req0 = 1'b1;
      tick();
      req0 = 1'b0;
      for (int t = 1; t <= 20; t++) begin
        if (fa < 0 && a_rsp_valid) fa = t;
        if (fb < 0 && b_rsp_valid) fb = t;
        if (fa >= 0 && fb >= 0) break;
        tick();
      end
      check("latency wait0", 32'(fa), 32'd2);
      check("latency wait3", 32'(fb), 32'd5);
    end
    repeat (6) tick();

    // Reset in WAIT: in-flight work dropped, requester 0 wins next contest.
    in0 = 16'h0080; msb0 = 4'd7; shf0 = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset in wait");
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("post reset a valid", 32'(a_rsp_valid), 32'd0);
      check("post reset b valid", 32'(b_rsp_valid), 32'd0);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    check("post reset contest ack0", 32'(a_ack0), 32'd1);
    check("post reset contest ack1", 32'(a_ack1), 32'd0);
    repeat (8) tick();

    // Randomized traffic with random backpressure.
    repeat (600) begin
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      in0 = 16'($urandom); in1 = 16'($urandom);
      msb0 = 4'($urandom_range(0, 15)); msb1 = 4'($urandom_range(0, 15));
      shf0 = 1'($urandom_range(0, 1)); shf1 = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
